oled_text_engine: RTL
=====================

Name: oled_text_engine

Overview:
- Parameterised successor to the fixed-string OLED font sequencer. Renders up to N_ENTRIES glyphs, each either 8x16 or 16x16, from an external descriptor table and glyph ROM.
- Emits 24-bit SSD1306 I2C write words {I2C_ADDR, ctrl, data} to the existing I2C writer using a valid/done handshake.
- New behaviour: per-pass dirty mask, so only changed fields are redrawn. Descriptor contents are external, so no glyph ID or position is hard-coded.

Parameters:
- N_ENTRIES, 16, number of descriptor entries.
- IDX_W, 4, entry index width; must satisfy 2^IDX_W >= N_ENTRIES.
- GLYPH_W, 6, glyph ID width.
- I2C_ADDR, 8'h78, first byte of every command word.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  pulse; begins one render pass.
- dirty_mask  in  N_ENTRIES  bit i=1 renders entry i; sampled only on the accepted start cycle.
- ent_sel  out  IDX_W  descriptor table index.
- ent_x  in  7  column 0..127 for ent_sel; combinational, valid same cycle.
- ent_page  in  3  start page for ent_sel.
- ent_wide  in  1  1=16x16, 0=8x16.
- ent_glyph  in  GLYPH_W  glyph ID.
- rom_addr  out  GLYPH_W+5  glyph ROM address = {glyph, row, col[3:0]}; 32-byte slot per glyph.
- rom_data  in  8  ROM output, 1-cycle registered latency.
- cmd_valid  out  1  cmd_data valid.
- cmd_data  out  24  I2C write word.
- cmd_done  in  1  I2C writer finished current word (1-cycle pulse).
- busy  out  1  pass in progress.
- done  out  1  1-cycle pulse at pass end.

Behaviour:
- Reset values: cmd_valid=0, cmd_data=0, ent_sel=0, rom_addr=0, busy=0, done=0; FSM=IDLE. Reset mid-pass aborts with no further words; the mask latch is cleared.
- IDLE:
  - start=1 latches dirty_mask, sets busy, goes to SCAN with ent_sel=0.
  - start while busy is ignored; the mask is not re-latched.
- SCAN (one entry per cycle):
  - Latched bit for ent_sel set: capture x/page/wide/glyph into registers, row=0, word=0, go to ADV.
  - Bit clear: ent_sel+1.
  - After entry N_ENTRIES-1: go to DONE.
- Word sequence per row (row 0 then row 1):
  - word 0 = {I2C_ADDR,8'h00,8'hB0+((page+row)&7)}. Page 7 with row 1 wraps to page 0.
  - word 1 = {I2C_ADDR,8'h00,{4'h0,x[3:0]}}.
  - word 2 = {I2C_ADDR,8'h00,{5'b00010,x[6:4]}}.
  - words 3..W+2 = {I2C_ADDR,8'h40,byte}, where W=16 if wide else 8 and byte = ROM byte at col=word-3.
- ADV: drive rom_addr for the current word (don't-care for words 0..2). Go to SEND one cycle later, giving ROM latency.
- SEND:
  - Raise cmd_valid; hold cmd_data stable until cmd_done is sampled high. Then drop cmd_valid and advance word → ADV.
  - cmd_done while cmd_valid=0 is ignored.
  - Inter-word gap is exactly 2 cycles of cmd_valid=0 (done cycle, ADV cycle).
- After the last data word of row 1: clear the latched bit, ent_sel+1, return to SCAN. If ent_sel was N_ENTRIES-1, go to DONE.
- DONE: done=1 for one cycle, busy=0 on the same edge, then IDLE.
- Timing:
  - All-zero mask: done asserts N_ENTRIES+1 cycles after start.
  - Word count per dirty entry: 2*(3+W) → 22 for narrow, 38 for wide.
- Arithmetic:
  - ent_sel increments modulo 2^IDX_W; the range is bounded by N_ENTRIES.
  - Column auto-increment beyond x+W>128 is left to the panel; no clamping.

Optional Feature:
- OLED_TEXT_INVERT_EN defined: extra input invert_mask [N_ENTRIES], latched with dirty_mask on start. Data bytes of entries with the latched bit set are sent as ~rom_data; command words are unaffected.
- Undefined: the port is absent and bytes pass through unchanged.

Test Plan:
- dirty_mask=0, start → no cmd_valid; done exactly N_ENTRIES+1=17 cycles after start; busy high 17 cycles.
- Entry 2 only: narrow, x=8, page=0, glyph=5; writer acks after 3 cycles → 22 words. First word 0x7800B0, then 0x780008, 0x780010. Data reads rom_addr 0x0A0..0x0A7 (row 0) and 0x0B0..0x0B7 (row 1). Row-1 header is 0x7800B1.
- Entry 0 wide, x=100 (0x64), page=7 → row-1 header 0x7800B0 (wrap), x words 0x780004/0x780016; 38 words total.
- start pulsed again mid-pass with a different mask → ignored; only the original mask's entries are emitted; a single done.
- rst asserted while cmd_valid=1 → cmd_valid=0, busy=0 next cycle. A new start then renders from entry 0.
- OLED_TEXT_INVERT_EN, invert_mask bit set, rom_data=0x3C → data words carry 0x7840C3.

Source files
------------

// File: rtl/oled_text_engine.sv
// oled_text_engine: renders dirty descriptor entries as SSD1306 I2C write words.
// Each selected entry emits, per glyph row (0 then 1), a page header, two
// column-address words and 8 or 16 glyph data bytes read from a 1-cycle ROM.
// Optional build macro OLED_TEXT_INVERT_EN adds invert_mask, latched on start,
// which sends the data bytes of the marked entries inverted.
//
// cmd_valid/cmd_done handshake: cmd_valid rises with cmd_data and both hold
// until cmd_done is sampled high while cmd_valid=1; cmd_valid then drops on
// that edge. cmd_done seen while cmd_valid=0 has no effect.
module oled_text_engine #(
  parameter int              N_ENTRIES = 16,
  parameter int              IDX_W     = 4,
  parameter int              GLYPH_W   = 6,
  parameter logic [7:0]      I2C_ADDR  = 8'h78
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_ENTRIES-1:0] dirty_mask,
`ifdef OLED_TEXT_INVERT_EN
  input  logic [N_ENTRIES-1:0] invert_mask,
`endif
  output logic [IDX_W-1:0]     ent_sel,
  input  logic [6:0]           ent_x,
  input  logic [2:0]           ent_page,
  input  logic                 ent_wide,
  input  logic [GLYPH_W-1:0]   ent_glyph,
  output logic [GLYPH_W+4:0]   rom_addr,
  input  logic [7:0]           rom_data,
  output logic                 cmd_valid,
  output logic [23:0]          cmd_data,
  input  logic                 cmd_done,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_ADV, S_SEND, S_DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

  state_t                 state_q, state_d;
  logic [N_ENTRIES-1:0]   mask_q, mask_d;
  logic [IDX_W-1:0]       ent_sel_q, ent_sel_d;
  logic [6:0]             x_q, x_d;
  logic [2:0]             page_q, page_d;
  logic                   wide_q, wide_d;
  logic [GLYPH_W-1:0]     glyph_q, glyph_d;
  logic                   row_q, row_d;
  logic [4:0]             word_q, word_d;
  logic [GLYPH_W+4:0]     rom_addr_q, rom_addr_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [23:0]            cmd_data_q, cmd_data_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   inv_bit;
  logic [2:0]             page_row;
  logic [4:0]             last_word;
  logic [23:0]            word_data;

`ifdef OLED_TEXT_INVERT_EN
  logic [N_ENTRIES-1:0]   inv_q, inv_d;
  assign inv_bit = inv_q[ent_sel_q];
`else
  assign inv_bit = 1'b0;
`endif

  // ROM slot address for a given word; columns start at word 3.
  function automatic logic [GLYPH_W+4:0] rom_slot(input logic [GLYPH_W-1:0] g,
                                                  input logic r,
                                                  input logic [4:0] w);
    return {g, r, 4'(w - 5'd3)};
  endfunction

  assign page_row  = page_q + {2'b00, row_q};
  assign last_word = wide_q ? 5'd18 : 5'd10;

  // Word contents for the current row/word position of the active entry.
  always_comb begin
    word_data = {I2C_ADDR, 8'h40, rom_data ^ {8{inv_bit}}};
    case (word_q)
      5'd0:    word_data = {I2C_ADDR, 8'h00, 5'b10110, page_row};
      5'd1:    word_data = {I2C_ADDR, 8'h00, 4'h0, x_q[3:0]};
      5'd2:    word_data = {I2C_ADDR, 8'h00, 5'b00010, x_q[6:4]};
      default: word_data = {I2C_ADDR, 8'h40, rom_data ^ {8{inv_bit}}};
    endcase
  end

  // Next-state and output logic for the render sequencer.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    ent_sel_d   = ent_sel_q;
    x_d         = x_q;
    page_d      = page_q;
    wide_d      = wide_q;
    glyph_d     = glyph_q;
    row_d       = row_q;
    word_d      = word_q;
    rom_addr_d  = rom_addr_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef OLED_TEXT_INVERT_EN
    inv_d       = inv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d    = dirty_mask;
`ifdef OLED_TEXT_INVERT_EN
          inv_d     = invert_mask;
`endif
          busy_d    = 1'b1;
          ent_sel_d = '0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (mask_q[ent_sel_q]) begin
          x_d        = ent_x;
          page_d     = ent_page;
          wide_d     = ent_wide;
          glyph_d    = ent_glyph;
          row_d      = 1'b0;
          word_d     = 5'd0;
          rom_addr_d = rom_slot(ent_glyph, 1'b0, 5'd0);
          state_d    = S_ADV;
        end else begin
          ent_sel_d = ent_sel_q + 1'b1;
          if (ent_sel_q == LAST_IDX) state_d = S_DONE;
        end
      end
      S_ADV: begin
        // rom_addr is already stable; this cycle covers the ROM latency.
        state_d = S_SEND;
      end
      S_SEND: begin
        if (!cmd_valid_q) begin
          cmd_valid_d = 1'b1;
          cmd_data_d  = word_data;
        end else if (cmd_done) begin
          cmd_valid_d = 1'b0;
          if (word_q != last_word) begin
            word_d     = word_q + 5'd1;
            rom_addr_d = rom_slot(glyph_q, row_q, word_q + 5'd1);
            state_d    = S_ADV;
          end else if (!row_q) begin
            row_d      = 1'b1;
            word_d     = 5'd0;
            rom_addr_d = rom_slot(glyph_q, 1'b1, 5'd0);
            state_d    = S_ADV;
          end else begin
            mask_d[ent_sel_q] = 1'b0;
            ent_sel_d         = ent_sel_q + 1'b1;
            state_d           = (ent_sel_q == LAST_IDX) ? S_DONE : S_SCAN;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset aborts any pass.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      ent_sel_q   <= '0;
      x_q         <= '0;
      page_q      <= '0;
      wide_q      <= 1'b0;
      glyph_q     <= '0;
      row_q       <= 1'b0;
      word_q      <= '0;
      rom_addr_q  <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef OLED_TEXT_INVERT_EN
      inv_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      ent_sel_q   <= ent_sel_d;
      x_q         <= x_d;
      page_q      <= page_d;
      wide_q      <= wide_d;
      glyph_q     <= glyph_d;
      row_q       <= row_d;
      word_q      <= word_d;
      rom_addr_q  <= rom_addr_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef OLED_TEXT_INVERT_EN
      inv_q       <= inv_d;
`endif
    end
  end

  assign ent_sel     = ent_sel_q;
  assign rom_addr    = rom_addr_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd_data    = cmd_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule
